serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing a − b − bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell plus a borrow flip-flop. It is the inverse-operation counterpart to the team's full-adder datapath.
- Accepts operands on a start pulse, runs for WIDTH cycles, then presents the result with a one-cycle done pulse.
- Intended as the subtract engine in small sequential ALU / arithmetic-unit experiments.

Parameters:
- WIDTH, 8, operand/result bit width; legal range ≥ 2. Counter width is derived internally as $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  initial borrow-in; captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  registered result a − b − bin (mod 2^WIDTH)
- borrow_out  output  1  final borrow; 1 iff a < b + bin (unsigned)
- overflow  output  1  signed overflow of a − b − bin (two's complement)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on any clk edge with rst=1, the block does the following. Reset has priority over all other inputs, including mid-RUN; a partial result is discarded.
  - state ← IDLE
  - busy=0, done=0, diff=0, borrow_out=0, overflow=0
  - internal shift registers, borrow FF and bit counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture a, b into shift registers; borrow FF ← bin; cnt ← 0; go to RUN.
  - With start=0: remain in IDLE.
- RUN: each edge processes the current LSBs ai, bi with borrow br.
  - d = ai ^ bi ^ br
  - br' = (~ai & bi) | (~(ai ^ bi) & br)
  - Shift d into the result shift register from the MSB side; shift the operands right; cnt ← cnt + 1.
  - On the edge where cnt == WIDTH−1, after processing the final bit, go to DONE. On that same edge:
    - diff ← complete result
    - borrow_out ← br'
    - overflow ← (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge returns unconditionally to IDLE.
  - start is ignored while in DONE.
- Latency:
  - Start accepted at edge k → busy=1 in cycles k+1..k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH.
  - Back in IDLE after edge k+WIDTH+1.
  - Next start can be accepted at edge k+WIDTH+2 at the earliest.
- start while busy or done: ignored; captured operands are unaffected.
- a/b/bin changes after capture: no effect on the operation in flight.
- Result holding: diff, borrow_out and overflow hold their values after done until the next completion. They are not cleared on a new start; only rst clears them.
- Wrap-around: result is modulo 2^WIDTH. The borrow is reported only via borrow_out.
- Counter must not overflow or wrap within RUN for any legal WIDTH.

Test Plan (WIDTH=8):
- Reset, then a=0x5A, b=0x3C, bin=0, start pulse → busy high 8 cycles, done pulse on cycle 9; diff=0x1E, borrow_out=0, overflow=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, borrow_out=1, overflow=0. Then a=0x10, b=0x0F, bin=1 → diff=0x00, borrow_out=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Start a=0x55, b=0x11. At cycle 3 of RUN, pulse start with a=0xFF, b=0x00 → ignored; result diff=0x44. Inputs changed mid-run have no effect.
- Start an operation and assert rst at RUN cycle 4 → next cycle busy=0, done=0, diff=0, borrow_out=0, overflow=0, state IDLE. No done pulse follows. A fresh start afterwards completes correctly.
- Back-to-back: hold start=1 continuously → ops accepted every WIDTH+2 cycles. The start asserted during DONE is ignored, and done pulses are exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop walk the captured operands.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; operands captured on accepted start
//   RUN   | one bit per edge, WIDTH edges total; busy=1
//   DONE  | one-cycle done pulse; result registers hold the answer
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_d;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             msb_a;
  logic             msb_b;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] result;

  // Full-subtractor cell on the current LSBs
  assign ai       = sh_a[0];
  assign bi       = sh_b[0];
  assign d        = ai ^ bi ^ br;
  assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
  assign last_bit = (cnt == CNT_LAST);
  assign result   = {d, sh_d[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counter holds at its terminal value on the final edge so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      msb_a      <= 1'b0;
      msb_b      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            br    <= bin;
            cnt   <= '0;
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1];
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= result;
          br   <= br_nxt;
          if (last_bit) begin
            diff       <= result;
            borrow_out <= br_nxt;
            overflow   <= (msb_a != msb_b) && (d != msb_a);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) with immediate-assertion checks.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then wait (bounded) for done; checks latency and busy span.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vbin, input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    int bc;
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy_cycles"}, bc, 8);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow_out, eb);
    chk({tag, "_ovf"}, overflow, eo);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    int bc;
    int seen;
    int t[3];
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    run_op("op5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("op00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("op10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("op80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("op7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Start ignored mid-run; inputs changed after capture; previous result held during run.
    repeat (3) @(negedge clk);
    chk("hold_idle_diff", diff, 8'h80);
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold_run_diff", diff, 8'h80);
    chk("hold_run_ovf", overflow, 1);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_latency", n, 5);
    chk("ign_diff", diff, 8'h44);
    chk("ign_borrow", borrow_out, 0);
    chk("ign_ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    chk("ign_no_restart", busy, 0);

    // Reset in the middle of a run
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_borrow", borrow_out, 0);
    chk("mid_rst_ovf", overflow, 0);
    seen = 0; bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
      if (busy) bc++;
    end
    chk("mid_rst_no_done", seen, 0);
    chk("mid_rst_stays_idle", bc, 0);
    run_op("after_rst", 8'h33, 8'h44, 1'b1, 8'hEE, 1'b1, 1'b0);

    // Back-to-back with start held high
    a = 8'h0F; b = 8'h01; bin = 1'b0; start = 1'b1;
    seen = 0; n = 0;
    while (seen < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        t[seen] = cyc;
        seen++;
      end
    end
    start = 1'b0;
    chk("b2b_pulses", seen, 3);
    if (seen == 3) begin
      chk("b2b_gap1", t[1] - t[0], 10);
      chk("b2b_gap2", t[2] - t[1], 10);
    end
    chk("b2b_diff", diff, 8'h0E);
    chk("b2b_borrow", borrow_out, 0);
    repeat (12) @(negedge clk);
    chk("b2b_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
